fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl_pkg.sv | 13 +
 rtl/fpu_issue_ctrl_watchdog.sv | 27 ++
 rtl/fpu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue path: FSM state encoding and opcode constants.
package fpu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } fpu_state_t;

  localparam logic [1:0] FOP_DIV = 2'b11;

endpackage

// File: rtl/fpu_issue_ctrl_watchdog.sv
// Cycle counter for an outstanding FPU operation; flags the last allowed wait cycle.
module fpu_watchdog #(
  parameter int LIMIT = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !limit_reached) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Counter holds the number of completed wait cycles, so the LIMIT-th wait cycle sees LIMIT-1.
  assign limit_reached = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FPU operation at a time, tracks it with a watchdog and arbitrates its writeback.
// Decode is frozen while an issue cannot be taken or a read hits the pending destination.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int WD_LIMIT = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [15:0] issue_opA,
  input  logic [15:0] issue_opB,
  input  logic [3:0]  issue_waddr,
  input  logic [3:0]  rd_addr0,
  input  logic [3:0]  rd_addr1,
  output logic        issue_ready,
  output logic        stall,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [15:0] fpu_opA,
  output logic [15:0] fpu_opB,
  input  logic        fpu_valid,
  input  logic        fpu_busy,
  input  logic [15:0] fpu_result,
  input  logic        fpu_ovf,
  input  logic        fpu_unf,
  input  logic        fpu_inx,
  output logic        wb_req,
  input  logic        wb_grant,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [2:0]  fflags,
  input  logic        clr_flags,
  output logic        wd_err
);

  fpu_state_t state, next_state;
  logic [3:0] waddr_q;
  logic       wd_hit;
  logic       accept;
  logic       capture;
  logic       raw_hit;

  fpu_watchdog #(.LIMIT(WD_LIMIT)) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .clear         (state == ST_START),
    .enable        (state == ST_WAIT),
    .limit_reached (wd_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (issue_valid && !fpu_busy) next_state = ST_START;
      ST_START: next_state = ST_WAIT;
      ST_WAIT: begin
        if (fpu_valid)   next_state = ST_WB;
        else if (wd_hit) next_state = ST_IDLE;
      end
      ST_WB:    if (wb_grant) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign raw_hit = (rd_addr0 == waddr_q) || (rd_addr1 == waddr_q);

  always_comb begin
    issue_ready = 1'b0;
    fpu_start   = 1'b0;
    wb_req      = 1'b0;
    wd_err      = 1'b0;
    stall       = 1'b0;
    case (state)
      ST_IDLE: begin
        issue_ready = issue_valid && !fpu_busy;
        stall       = fpu_busy;
      end
      ST_START: begin
        fpu_start = 1'b1;
        stall     = issue_valid || raw_hit;
      end
      ST_WAIT: begin
        wd_err = wd_hit && !fpu_valid;
        stall  = issue_valid || raw_hit;
      end
      ST_WB: begin
        wb_req = 1'b1;
        stall  = issue_valid || raw_hit;
      end
      default: ;
    endcase
  end

  assign accept  = (state == ST_IDLE) && issue_valid && !fpu_busy;
  assign capture = (state == ST_WAIT) && fpu_valid;
  assign wb_addr = waddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpu_op  <= '0;
      fpu_opA <= '0;
      fpu_opB <= '0;
      waddr_q <= '0;
      wb_data <= '0;
      fflags  <= '0;
    end else begin
      if (accept) begin
        fpu_op  <= issue_op;
        fpu_opA <= issue_opA;
        fpu_opB <= issue_opB;
        waddr_q <= issue_waddr;
      end
      if (capture) wb_data <= fpu_result;
      // A flag capture in the same cycle as a clear keeps the new flags.
      if (capture)        fflags <= fflags | {fpu_ovf, fpu_unf, fpu_inx};
      else if (clr_flags) fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: issue/writeback, hazards, watchdog, flags and reset.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int WD = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [15:0] issue_opA, issue_opB;
  logic [3:0]  issue_waddr, rd_addr0, rd_addr1;
  logic        issue_ready, stall, fpu_start;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_opA, fpu_opB;
  logic        fpu_valid, fpu_busy;
  logic [15:0] fpu_result;
  logic        fpu_ovf, fpu_unf, fpu_inx;
  logic        wb_req, wb_grant;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  fflags;
  logic        clr_flags, wd_err;

  int n_chk  = 0;
  int n_pass = 0;

  fpu_issue_ctrl #(.WD_LIMIT(WD)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_waddr(issue_waddr),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .issue_ready(issue_ready), .stall(stall), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_opA(fpu_opA), .fpu_opB(fpu_opB),
    .fpu_valid(fpu_valid), .fpu_busy(fpu_busy), .fpu_result(fpu_result),
    .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_inx(fpu_inx),
    .wb_req(wb_req), .wb_grant(wb_grant), .wb_addr(wb_addr), .wb_data(wb_data),
    .fflags(fflags), .clr_flags(clr_flags), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] wa);
    issue_valid = 1'b1; issue_op = op; issue_opA = a; issue_opB = b; issue_waddr = wa;
    #1;
    chk("issue_ready_idle", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 0; issue_op = 0; issue_opA = 0; issue_opB = 0;
    issue_waddr = 0; rd_addr0 = 0; rd_addr1 = 0; fpu_valid = 0; fpu_busy = 0;
    fpu_result = 0; fpu_ovf = 0; fpu_unf = 0; fpu_inx = 0; wb_grant = 0; clr_flags = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fpu_start", {31'd0, fpu_start}, 32'd0);
    chk("rst_wb_req", {31'd0, wb_req}, 32'd0);
    chk("rst_wd_err", {31'd0, wd_err}, 32'd0);
    chk("rst_fflags", {29'd0, fflags}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("rst_fpu_opA", {16'd0, fpu_opA}, 32'd0);

    // Basic add: result two cycles after start.
    issue(2'b00, 16'h3C00, 16'h4000, 4'd5);
    #1;
    chk("start_pulse", {31'd0, fpu_start}, 32'd1);
    chk("lat_opA", {16'd0, fpu_opA}, 32'h3C00);
    chk("lat_opB", {16'd0, fpu_opB}, 32'h4000);
    chk("lat_op", {30'd0, fpu_op}, 32'd0);
    tick();
    #1;
    chk("start_one_cycle", {31'd0, fpu_start}, 32'd0);
    chk("no_wb_wait1", {31'd0, wb_req}, 32'd0);
    tick();
    fpu_valid = 1; fpu_result = 16'h4200; fpu_inx = 1;
    tick();
    fpu_valid = 0; fpu_result = 16'h0; fpu_inx = 0; wb_grant = 1;
    #1;
    chk("wb_req_add", {31'd0, wb_req}, 32'd1);
    chk("wb_addr_add", {28'd0, wb_addr}, 32'd5);
    chk("wb_data_add", {16'd0, wb_data}, 32'h4200);
    chk("fflags_inx", {29'd0, fflags}, 32'h1);
    tick();
    wb_grant = 0;
    #1;
    chk("idle_after_grant", {31'd0, wb_req}, 32'd0);

    // Divide with RAW hazard, a second issue during WAIT and delayed grant.
    issue(FOP_DIV, 16'h4400, 16'h4000, 4'd3);
    rd_addr1 = 4'd3; fpu_valid = 1; fpu_result = 16'h1111;
    #1;
    chk("raw_stall", {31'd0, stall}, 32'd1);
    chk("lat_op_div", {30'd0, fpu_op}, {30'd0, FOP_DIV});
    tick();
    fpu_valid = 0; rd_addr1 = 4'd4;
    #1;
    chk("no_raw_stall", {31'd0, stall}, 32'd0);
    chk("start_valid_ignored", {31'd0, wb_req}, 32'd0);
    issue_valid = 1; issue_op = 2'b00; issue_waddr = 4'd9;
    #1;
    chk("busy_issue_stall", {31'd0, stall}, 32'd1);
    chk("busy_issue_not_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    fpu_valid = 1; fpu_result = 16'hABCD; fpu_ovf = 1;
    tick();
    fpu_valid = 0; fpu_ovf = 0; fpu_result = 16'h0;
    #1;
    chk("wb_stall", {31'd0, stall}, 32'd1);
    chk("wb_not_ready", {31'd0, issue_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_wb_req", {31'd0, wb_req}, 32'd1);
      chk("hold_wb_data", {16'd0, wb_data}, 32'hABCD);
      chk("hold_wb_addr", {28'd0, wb_addr}, 32'd3);
      tick();
    end
    wb_grant = 1;
    #1;
    chk("grant6_wb_req", {31'd0, wb_req}, 32'd1);
    tick();
    wb_grant = 0;
    #1;
    chk("idle_ready_again", {31'd0, issue_ready}, 32'd1);
    chk("idle_no_stall", {31'd0, stall}, 32'd0);
    chk("fflags_sticky", {29'd0, fflags}, 32'h5);
    fpu_busy = 1;
    #1;
    chk("idle_busy_stall", {31'd0, stall}, 32'd1);
    chk("idle_busy_not_ready", {31'd0, issue_ready}, 32'd0);
    issue_valid = 0; fpu_busy = 0; clr_flags = 1;
    tick();
    clr_flags = 0;
    #1;
    chk("clr_flags", {29'd0, fflags}, 32'd0);

    // Watchdog: no result ever arrives.
    issue(2'b01, 16'h1, 16'h2, 4'd7);
    tick();
    for (int k = 1; k <= WD; k++) begin
      #1;
      chk("wd_err_timing", {31'd0, wd_err}, (k == WD) ? 32'd1 : 32'd0);
      chk("wd_no_wb", {31'd0, wb_req}, 32'd0);
      tick();
    end
    #1;
    chk("wd_err_single", {31'd0, wd_err}, 32'd0);
    chk("wd_no_wb_after", {31'd0, wb_req}, 32'd0);
    chk("wd_wb_data_kept", {16'd0, wb_data}, 32'hABCD);

    // Flag capture coinciding with clear.
    issue(2'b10, 16'h5, 16'h6, 4'd2);
    tick();
    fpu_valid = 1; fpu_unf = 1; fpu_result = 16'h0BEE; clr_flags = 1;
    tick();
    fpu_valid = 0; fpu_unf = 0; clr_flags = 0; wb_grant = 1;
    #1;
    chk("capture_beats_clear", {29'd0, fflags}, 32'h2);
    tick();
    wb_grant = 0;

    // Reset during WAIT abandons the operation.
    issue(2'b01, 16'h7777, 16'h8888, 4'd6);
    tick();
    rd_addr0 = 4'd6;
    #1;
    chk("wait_raw_stall", {31'd0, stall}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_fflags", {29'd0, fflags}, 32'd0);
    chk("mid_rst_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("mid_rst_opA", {16'd0, fpu_opA}, 32'd0);
    chk("mid_rst_opB", {16'd0, fpu_opB}, 32'd0);
    chk("mid_rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("mid_rst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("mid_rst_start", {31'd0, fpu_start}, 32'd0);
    chk("mid_rst_ready", {31'd0, issue_ready}, 32'd0);
    for (int k = 0; k < WD + 2; k++) begin
      #1;
      chk("post_rst_no_wb", {31'd0, wb_req}, 32'd0);
      chk("post_rst_no_wd", {31'd0, wd_err}, 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
